// File: rtl/udp_axil_pkg.sv
// Shared definitions for the UDP register-access protocol. The initiator and
// the remote udp_axil_bridge both import this package, so both ends agree on
// the request/reply word layout.
//
// Request/reply word (64 bits): opcode[63:62], address[61:32], data[31:0].
// On the wire, byte k is word[8k+7:8k] and bytes go out for k = 0..7. Byte 0
// is the data LSB and byte 7 carries the opcode.
package udp_axil_pkg;

  typedef enum logic [1:0] {
    WRITE_DATA = 2'd0,
    READ_DATA  = 2'd1,
    WRITE_OK   = 2'd2,
    READ_OK    = 2'd3
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [29:0] addr;
    logic [31:0] data;
  } request_t;

  // bytes[k] aliases word[8k+7:8k], which is the wire order.
  typedef union packed {
    request_t        req;
    logic [7:0][7:0] bytes;
    logic [63:0]     word;
  } request_union_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_PRIVILEGED  = 3'b001;
  localparam logic [2:0] AXI_PROT_NONSECURE   = 3'b010;
  localparam logic [2:0] AXI_PROT_INSTRUCTION = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_TX_HEADER  = 3'd1,
    ST_TX_PAYLOAD = 3'd2,
    ST_RX_HEADER  = 3'd3,
    ST_RX_PAYLOAD = 3'd4,
    ST_RX_DISCARD = 3'd5,
    ST_DRAIN      = 3'd6,
    ST_AXI_RESP   = 3'd7
  } init_state_t;

endpackage

// File: rtl/udp_axil_initiator.sv
// udp_axil_initiator: AXI-Lite slave that tunnels each access as one 8-byte
// UDP request to a remote udp_axil_bridge and turns the matching reply into
// the AXI-Lite B/R response. One access is outstanding at a time.
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   axil_*               32-bit AXI-Lite slave (AW, W, B, AR, R channels)
//   udp_tx_hdr_*, udp_tx_ip_*, udp_tx_*_port, udp_tx_length/checksum
//                        outgoing UDP header
//   udp_tx_payload_*     outgoing request bytes (AXI-Stream, 8-bit)
//   udp_rx_hdr_*, udp_rx_ip_source_ip, udp_rx_*_port
//                        incoming UDP header (only the filter fields)
//   udp_rx_payload_*     incoming reply bytes (AXI-Stream, 8-bit)
//   busy                 high from request capture until the response is taken
//   timeout              one-cycle pulse when the reply wait expires
//   dbg_state            current FSM state
//
// Handshakes: every channel transfers on a rising clk edge where valid and
// ready are both high. A source holds valid and its payload stable until that
// edge; ready may depend combinationally on valid.
module udp_axil_initiator
  import udp_axil_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP       = 32'hC0A8_0102,
  parameter logic [31:0] REMOTE_IP      = 32'hC0A8_0101,
  parameter logic [15:0] LOCAL_PORT     = 16'd1235,
  parameter logic [15:0] REMOTE_PORT    = 16'd1234,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] axil_awaddr,
  input  logic        axil_awvalid,
  output logic        axil_awready,
  input  logic [31:0] axil_wdata,
  input  logic [3:0]  axil_wstrb,
  input  logic        axil_wvalid,
  output logic        axil_wready,
  output logic [1:0]  axil_bresp,
  output logic        axil_bvalid,
  input  logic        axil_bready,
  input  logic [31:0] axil_araddr,
  input  logic        axil_arvalid,
  output logic        axil_arready,
  output logic [31:0] axil_rdata,
  output logic [1:0]  axil_rresp,
  output logic        axil_rvalid,
  input  logic        axil_rready,
  output logic        udp_tx_hdr_valid,
  input  logic        udp_tx_hdr_ready,
  output logic [5:0]  udp_tx_ip_dscp,
  output logic [1:0]  udp_tx_ip_ecn,
  output logic [7:0]  udp_tx_ip_ttl,
  output logic [31:0] udp_tx_ip_source_ip,
  output logic [31:0] udp_tx_ip_dest_ip,
  output logic [15:0] udp_tx_source_port,
  output logic [15:0] udp_tx_dest_port,
  output logic [15:0] udp_tx_length,
  output logic [15:0] udp_tx_checksum,
  output logic [7:0]  udp_tx_payload_tdata,
  output logic        udp_tx_payload_tvalid,
  input  logic        udp_tx_payload_tready,
  output logic        udp_tx_payload_tlast,
  output logic        udp_tx_payload_tuser,
  input  logic        udp_rx_hdr_valid,
  output logic        udp_rx_hdr_ready,
  input  logic [31:0] udp_rx_ip_source_ip,
  input  logic [15:0] udp_rx_source_port,
  input  logic [15:0] udp_rx_dest_port,
  input  logic [7:0]  udp_rx_payload_tdata,
  input  logic        udp_rx_payload_tvalid,
  output logic        udp_rx_payload_tready,
  input  logic        udp_rx_payload_tlast,
  input  logic        udp_rx_payload_tuser,
  output logic        busy,
  output logic        timeout,
  output init_state_t dbg_state
);

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

  init_state_t    state, state_n;
  request_union_t req, req_n;
  request_union_t reply, reply_n;
  logic           is_read, is_read_n;
  logic           prio_read, prio_read_n;  // 1: read wins a collision
  logic [2:0]     byte_cnt, byte_cnt_n;
  logic [31:0]    timer, timer_n;
  logic           bad, bad_n;              // reply ran past byte 7 without tlast
  logic [1:0]     resp, resp_n;
  logic [31:0]    resp_data, resp_data_n;

  logic           take_read, take_write, timer_hit, rx_match;
  request_union_t rx_word;

  assign take_read  = reset_n && axil_arvalid &&
                      (!(axil_awvalid && axil_wvalid) || prio_read);
  assign take_write = reset_n && axil_awvalid && axil_wvalid && !take_read;
  assign timer_hit  = (timer == TIMER_LAST);
  assign rx_match   = (udp_rx_ip_source_ip == REMOTE_IP) &&
                      (udp_rx_source_port == REMOTE_PORT) &&
                      (udp_rx_dest_port == LOCAL_PORT);

  assign udp_tx_ip_dscp      = 6'd0;
  assign udp_tx_ip_ecn       = 2'd0;
  assign udp_tx_ip_ttl       = 8'd64;
  assign udp_tx_ip_source_ip = LOCAL_IP;
  assign udp_tx_ip_dest_ip   = REMOTE_IP;
  assign udp_tx_source_port  = LOCAL_PORT;
  assign udp_tx_dest_port    = REMOTE_PORT;
  assign udp_tx_length       = 16'd16;
  assign udp_tx_checksum     = 16'd0;
  assign udp_tx_payload_tdata = req.bytes[byte_cnt];
  assign udp_tx_payload_tuser = 1'b0;

  assign axil_bresp = resp;
  assign axil_rresp = resp;
  assign axil_rdata = resp_data;
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      req       <= '0;
      reply     <= '0;
      is_read   <= 1'b0;
      prio_read <= 1'b1;
      byte_cnt  <= 3'd0;
      timer     <= 32'd0;
      bad       <= 1'b0;
      resp      <= AXI_RESP_OKAY;
      resp_data <= 32'd0;
    end else begin
      state     <= state_n;
      req       <= req_n;
      reply     <= reply_n;
      is_read   <= is_read_n;
      prio_read <= prio_read_n;
      byte_cnt  <= byte_cnt_n;
      timer     <= timer_n;
      bad       <= bad_n;
      resp      <= resp_n;
      resp_data <= resp_data_n;
    end
  end

  always_comb begin
    state_n     = state;
    req_n       = req;
    reply_n     = reply;
    is_read_n   = is_read;
    prio_read_n = prio_read;
    byte_cnt_n  = byte_cnt;
    timer_n     = timer;
    bad_n       = bad;
    resp_n      = resp;
    resp_data_n = resp_data;
    rx_word     = reply;
    axil_awready = 1'b0;
    axil_wready  = 1'b0;
    axil_arready = 1'b0;
    axil_bvalid  = 1'b0;
    axil_rvalid  = 1'b0;
    udp_tx_hdr_valid      = 1'b0;
    udp_tx_payload_tvalid = 1'b0;
    udp_tx_payload_tlast  = 1'b0;
    udp_rx_hdr_ready      = 1'b0;
    udp_rx_payload_tready = 1'b0;
    timeout               = 1'b0;

    case (state)
      ST_IDLE: begin
        if (take_read || take_write) begin
          prio_read_n        = ~prio_read;
          is_read_n          = take_read;
          req_n.req.opcode   = take_read ? READ_DATA : WRITE_DATA;
          req_n.req.addr     = take_read ? axil_araddr[29:0] : axil_awaddr[29:0];
          req_n.req.data     = take_read ? 32'd0 : axil_wdata;
          axil_arready       = take_read;
          axil_awready       = take_write;
          axil_wready        = take_write;
          // Requests the bridge cannot express fail locally, without traffic.
          if (take_read ? (axil_araddr[31:30] != 2'b00)
                        : (axil_awaddr[31:30] != 2'b00 || axil_wstrb != 4'hF)) begin
            resp_n      = AXI_RESP_SLVERR;
            resp_data_n = 32'd0;
            state_n     = ST_AXI_RESP;
          end else begin
            state_n = ST_TX_HEADER;
          end
        end
      end

      ST_TX_HEADER: begin
        udp_tx_hdr_valid = 1'b1;
        if (udp_tx_hdr_ready) begin
          byte_cnt_n = 3'd0;
          state_n    = ST_TX_PAYLOAD;
        end
      end

      ST_TX_PAYLOAD: begin
        udp_tx_payload_tvalid = 1'b1;
        udp_tx_payload_tlast  = (byte_cnt == 3'd7);
        if (udp_tx_payload_tready) begin
          byte_cnt_n = byte_cnt + 3'd1;
          if (byte_cnt == 3'd7) begin
            timer_n = 32'd0;
            state_n = ST_RX_HEADER;
          end
        end
      end

      ST_RX_HEADER: begin
        timer_n = timer + 32'd1;
        // Refuse the header on the expiry cycle so its payload is not orphaned.
        udp_rx_hdr_ready = !timer_hit;
        if (timer_hit) begin
          timeout     = 1'b1;
          resp_n      = AXI_RESP_SLVERR;
          resp_data_n = 32'd0;
          state_n     = ST_AXI_RESP;
        end else if (udp_rx_hdr_valid) begin
          byte_cnt_n = 3'd0;
          bad_n      = 1'b0;
          state_n    = rx_match ? ST_RX_PAYLOAD : ST_RX_DISCARD;
        end
      end

      ST_RX_DISCARD, ST_RX_PAYLOAD: begin
        timer_n = timer + 32'd1;
        udp_rx_payload_tready = 1'b1;
        if (timer_hit) begin
          // Finish the packet in flight silently before answering the master.
          timeout     = 1'b1;
          resp_n      = AXI_RESP_SLVERR;
          resp_data_n = 32'd0;
          state_n     = (udp_rx_payload_tvalid && udp_rx_payload_tlast) ? ST_AXI_RESP
                                                                        : ST_DRAIN;
        end else if (udp_rx_payload_tvalid) begin
          if (state == ST_RX_DISCARD) begin
            if (udp_rx_payload_tlast) state_n = ST_RX_HEADER;
          end else begin
            rx_word.bytes[byte_cnt] = udp_rx_payload_tdata;
            reply_n = rx_word;
            if (udp_rx_payload_tlast) begin
              if (!bad && byte_cnt == 3'd7 && !udp_rx_payload_tuser &&
                  rx_word.req.addr == req.req.addr &&
                  rx_word.req.opcode[0] == req.req.opcode[0]) begin
                resp_n      = rx_word.req.opcode[1] ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                resp_data_n = (is_read && rx_word.req.opcode[1]) ? rx_word.req.data
                                                                 : 32'd0;
                state_n     = ST_AXI_RESP;
              end else begin
                state_n = ST_RX_HEADER;
              end
            end else if (byte_cnt == 3'd7) begin
              bad_n = 1'b1;
            end else begin
              byte_cnt_n = byte_cnt + 3'd1;
            end
          end
        end
      end

      ST_DRAIN: begin
        udp_rx_payload_tready = 1'b1;
        if (udp_rx_payload_tvalid && udp_rx_payload_tlast) state_n = ST_AXI_RESP;
      end

      ST_AXI_RESP: begin
        axil_bvalid = !is_read;
        axil_rvalid = is_read;
        if (is_read ? axil_rready : axil_bready) state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_udp_axil_initiator.sv
module tb_udp_axil_initiator;
  import udp_axil_pkg::*;

  localparam int LIMIT = 300;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] axil_awaddr = '0;
  logic        axil_awvalid = 1'b0;
  logic        axil_awready;
  logic [31:0] axil_wdata = '0;
  logic [3:0]  axil_wstrb = '0;
  logic        axil_wvalid = 1'b0;
  logic        axil_wready;
  logic [1:0]  axil_bresp;
  logic        axil_bvalid;
  logic        axil_bready = 1'b0;
  logic [31:0] axil_araddr = '0;
  logic        axil_arvalid = 1'b0;
  logic        axil_arready;
  logic [31:0] axil_rdata;
  logic [1:0]  axil_rresp;
  logic        axil_rvalid;
  logic        axil_rready = 1'b0;
  logic        udp_tx_hdr_valid;
  logic        udp_tx_hdr_ready = 1'b1;
  logic [5:0]  udp_tx_ip_dscp;
  logic [1:0]  udp_tx_ip_ecn;
  logic [7:0]  udp_tx_ip_ttl;
  logic [31:0] udp_tx_ip_source_ip;
  logic [31:0] udp_tx_ip_dest_ip;
  logic [15:0] udp_tx_source_port;
  logic [15:0] udp_tx_dest_port;
  logic [15:0] udp_tx_length;
  logic [15:0] udp_tx_checksum;
  logic [7:0]  udp_tx_payload_tdata;
  logic        udp_tx_payload_tvalid;
  logic        udp_tx_payload_tready = 1'b1;
  logic        udp_tx_payload_tlast;
  logic        udp_tx_payload_tuser;
  logic        udp_rx_hdr_valid = 1'b0;
  logic        udp_rx_hdr_ready;
  logic [31:0] udp_rx_ip_source_ip = '0;
  logic [15:0] udp_rx_source_port = '0;
  logic [15:0] udp_rx_dest_port = '0;
  logic [7:0]  udp_rx_payload_tdata = '0;
  logic        udp_rx_payload_tvalid = 1'b0;
  logic        udp_rx_payload_tready;
  logic        udp_rx_payload_tlast = 1'b0;
  logic        udp_rx_payload_tuser = 1'b0;
  logic        busy;
  logic        timeout;
  init_state_t dbg_state;

  udp_axil_initiator #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n),
    .axil_awaddr(axil_awaddr), .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
    .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb), .axil_wvalid(axil_wvalid),
    .axil_wready(axil_wready), .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid),
    .axil_bready(axil_bready), .axil_araddr(axil_araddr), .axil_arvalid(axil_arvalid),
    .axil_arready(axil_arready), .axil_rdata(axil_rdata), .axil_rresp(axil_rresp),
    .axil_rvalid(axil_rvalid), .axil_rready(axil_rready),
    .udp_tx_hdr_valid(udp_tx_hdr_valid), .udp_tx_hdr_ready(udp_tx_hdr_ready),
    .udp_tx_ip_dscp(udp_tx_ip_dscp), .udp_tx_ip_ecn(udp_tx_ip_ecn),
    .udp_tx_ip_ttl(udp_tx_ip_ttl), .udp_tx_ip_source_ip(udp_tx_ip_source_ip),
    .udp_tx_ip_dest_ip(udp_tx_ip_dest_ip), .udp_tx_source_port(udp_tx_source_port),
    .udp_tx_dest_port(udp_tx_dest_port), .udp_tx_length(udp_tx_length),
    .udp_tx_checksum(udp_tx_checksum),
    .udp_tx_payload_tdata(udp_tx_payload_tdata), .udp_tx_payload_tvalid(udp_tx_payload_tvalid),
    .udp_tx_payload_tready(udp_tx_payload_tready), .udp_tx_payload_tlast(udp_tx_payload_tlast),
    .udp_tx_payload_tuser(udp_tx_payload_tuser),
    .udp_rx_hdr_valid(udp_rx_hdr_valid), .udp_rx_hdr_ready(udp_rx_hdr_ready),
    .udp_rx_ip_source_ip(udp_rx_ip_source_ip), .udp_rx_source_port(udp_rx_source_port),
    .udp_rx_dest_port(udp_rx_dest_port),
    .udp_rx_payload_tdata(udp_rx_payload_tdata), .udp_rx_payload_tvalid(udp_rx_payload_tvalid),
    .udp_rx_payload_tready(udp_rx_payload_tready), .udp_rx_payload_tlast(udp_rx_payload_tlast),
    .udp_rx_payload_tuser(udp_rx_payload_tuser),
    .busy(busy), .timeout(timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int hdr_count = 0;
  logic [8:0] exp_q[$];  // {tlast, byte} expected on the TX payload

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_tx(input logic [63:0] word);
    for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), word[8*k +: 8]});
  endtask

  // TX monitor: header fields and payload bytes against the expected queue.
  always @(negedge clk) begin
    logic [8:0] e;
    #2;
    if (reset_n && udp_tx_hdr_valid && udp_tx_hdr_ready) begin
      hdr_count++;
      check("tx_hdr_ips", {udp_tx_ip_source_ip, udp_tx_ip_dest_ip}, {32'hC0A8_0102, 32'hC0A8_0101});
      check("tx_hdr_fields",
            {udp_tx_ip_ttl, udp_tx_ip_dscp, udp_tx_ip_ecn, udp_tx_source_port,
             udp_tx_dest_port, udp_tx_length, udp_tx_checksum},
            {8'd64, 6'd0, 2'd0, 16'd1235, 16'd1234, 16'd16, 16'd0});
    end
    if (reset_n && udp_tx_payload_tvalid && udp_tx_payload_tready) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected_byte", {udp_tx_payload_tlast, udp_tx_payload_tdata}, 9'h1FF);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", {udp_tx_payload_tuser, udp_tx_payload_tlast, udp_tx_payload_tdata},
              {1'b0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic axi_write_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    axil_awaddr = a; axil_wdata = d; axil_wstrb = s;
    axil_awvalid = 1'b1; axil_wvalid = 1'b1;
    #1;
    while (!axil_awready && n < LIMIT) begin sample(); n++; end
    if (n >= LIMIT) check("awready_wait", 0, 1);
    else check("wready_with_awready", axil_wready, 1);
    @(posedge clk);
    #1 axil_awvalid = 1'b0; axil_wvalid = 1'b0;
  endtask

  task automatic axi_read_req(input logic [31:0] a);
    int n = 0;
    @(negedge clk);
    axil_araddr = a; axil_arvalid = 1'b1;
    #1;
    while (!axil_arready && n < LIMIT) begin sample(); n++; end
    if (n >= LIMIT) check("arready_wait", 0, 1);
    @(posedge clk);
    #1 axil_arvalid = 1'b0;
  endtask

  task automatic wait_b(input string tag, input logic [1:0] er);
    int n = 0;
    @(negedge clk);
    axil_bready = 1'b1;
    #1;
    while (!axil_bvalid && n < LIMIT) begin sample(); n++; end
    if (n >= LIMIT) check({tag, "_bvalid_wait"}, 0, 1);
    else check({tag, "_bresp"}, axil_bresp, er);
    @(posedge clk);
    #1 axil_bready = 1'b0;
  endtask

  task automatic wait_r(input string tag, input logic [1:0] er, input logic [31:0] ed);
    int n = 0;
    @(negedge clk);
    axil_rready = 1'b1;
    #1;
    while (!axil_rvalid && n < LIMIT) begin sample(); n++; end
    if (n >= LIMIT) check({tag, "_rvalid_wait"}, 0, 1);
    else check({tag, "_rresp_rdata"}, {axil_rresp, axil_rdata}, {er, ed});
    @(posedge clk);
    #1 axil_rready = 1'b0;
  endtask

  // One reply packet: header, then 8 bytes word[7:0] first, tuser on the last.
  task automatic send_rx(input logic [31:0] sip, input logic [15:0] sp, input logic [15:0] dp,
                         input logic [63:0] w, input logic user);
    int n = 0;
    @(negedge clk);
    udp_rx_hdr_valid = 1'b1; udp_rx_ip_source_ip = sip;
    udp_rx_source_port = sp; udp_rx_dest_port = dp;
    #1;
    while (!udp_rx_hdr_ready && n < LIMIT) begin sample(); n++; end
    if (n >= LIMIT) begin
      check("rx_hdr_ready_wait", 0, 1);
      udp_rx_hdr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 udp_rx_hdr_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      udp_rx_payload_tvalid = 1'b1; udp_rx_payload_tdata = w[8*k +: 8];
      udp_rx_payload_tlast = (k == 7); udp_rx_payload_tuser = (k == 7) && user;
      n = 0;
      #1;
      while (!udp_rx_payload_tready && n < LIMIT) begin sample(); n++; end
      if (n >= LIMIT) begin
        check("rx_tready_wait", 0, 1);
        udp_rx_payload_tvalid = 1'b0; udp_rx_payload_tlast = 1'b0; udp_rx_payload_tuser = 1'b0;
        return;
      end
      @(posedge clk);
      #1 udp_rx_payload_tvalid = 1'b0; udp_rx_payload_tlast = 1'b0; udp_rx_payload_tuser = 1'b0;
    end
  endtask

  function automatic logic [10:0] idle_vec();
    return {axil_awready, axil_wready, axil_arready, axil_bvalid, axil_rvalid,
            udp_tx_hdr_valid, udp_tx_payload_tvalid, udp_rx_hdr_ready,
            udp_rx_payload_tready, busy, timeout};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic any;

    // Reset state
    repeat (3) @(posedge clk);
    sample();
    check("reset_outputs", idle_vec(), 11'd0);
    check("reset_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Collision of two locally failing requests: read wins first after reset.
    @(negedge clk);
    axil_awaddr = 32'h0000_0010; axil_wdata = 32'h1111_2222; axil_wstrb = 4'h3;
    axil_awvalid = 1'b1; axil_wvalid = 1'b1;
    axil_araddr = 32'h4000_0000; axil_arvalid = 1'b1;
    #1;
    check("collision_ready", {axil_arready, axil_awready, axil_wready}, 3'b100);
    @(posedge clk);
    #1 axil_arvalid = 1'b0;
    wait_r("addr_err_read", AXI_RESP_SLVERR, 32'd0);
    sample();
    check("pending_write_taken", {axil_awready, axil_wready}, 2'b11);
    @(posedge clk);
    #1 axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    wait_b("wstrb_err_write", AXI_RESP_SLVERR);
    axi_write_req(32'h4000_0010, 32'h0, 4'hF);
    wait_b("addr_err_write", AXI_RESP_SLVERR);
    check("no_tx_on_local_error", hdr_count, 0);

    // Write 0x10 = DEADBEEF, reply WRITE_OK
    exp_q.push_back(9'h0EF); exp_q.push_back(9'h0BE); exp_q.push_back(9'h0AD);
    exp_q.push_back(9'h0DE); exp_q.push_back(9'h010); exp_q.push_back(9'h000);
    exp_q.push_back(9'h000); exp_q.push_back(9'h100);
    axi_write_req(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    sample();
    check("hdr_valid_after_accept", {udp_tx_hdr_valid, busy}, 2'b11);
    send_rx(32'hC0A8_0101, 16'd1234, 16'd1235, 64'h8000_0010_0000_0000, 1'b0);
    sample();
    check("bvalid_after_reply_tlast", axil_bvalid, 1);
    wait_b("write_ok", AXI_RESP_OKAY);
    check("write_tx_all_bytes", exp_q.size(), 0);
    sample();
    check("busy_clear", busy, 0);

    // Same write, reply opcode 0 -> SLVERR
    push_tx(64'h0000_0010_DEAD_BEEF);
    axi_write_req(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    send_rx(32'hC0A8_0101, 16'd1234, 16'd1235, 64'h0000_0010_0000_0000, 1'b0);
    wait_b("write_nok", AXI_RESP_SLVERR);

    // Read 0x04: byte7 = 0x40, reply READ_OK 0x12345678
    exp_q.push_back(9'h000); exp_q.push_back(9'h000); exp_q.push_back(9'h000);
    exp_q.push_back(9'h000); exp_q.push_back(9'h004); exp_q.push_back(9'h000);
    exp_q.push_back(9'h000); exp_q.push_back(9'h140);
    axi_read_req(32'h0000_0004);
    send_rx(32'hC0A8_0101, 16'd1234, 16'd1235, 64'hC000_0004_1234_5678, 1'b0);
    sample();
    check("rvalid_after_reply_tlast", axil_rvalid, 1);
    wait_r("read_ok", AXI_RESP_OKAY, 32'h1234_5678);

    // Read with rejected replies ahead of the good one
    push_tx(64'h4000_0004_0000_0000);
    axi_read_req(32'h0000_0004);
    send_rx(32'hC0A8_0101, 16'd1111, 16'd1235, 64'hC000_0004_9999_9999, 1'b0);
    sample();
    check("wrong_port_discarded", {dbg_state, axil_rvalid}, {ST_RX_HEADER, 1'b0});
    send_rx(32'hC0A8_0101, 16'd1234, 16'd1235, 64'hC000_0008_1111_1111, 1'b0);
    send_rx(32'hC0A8_0101, 16'd1234, 16'd1235, 64'hC000_0004_2222_2222, 1'b1);
    send_rx(32'hC0A8_0101, 16'd1234, 16'd1235, 64'h8000_0004_3333_3333, 1'b0);
    sample();
    check("bad_replies_no_resp", {dbg_state, axil_rvalid, timeout}, {ST_RX_HEADER, 2'b00});
    send_rx(32'hC0A8_0101, 16'd1234, 16'd1235, 64'hC000_0004_CAFE_F00D, 1'b0);
    wait_r("read_after_rejects", AXI_RESP_OKAY, 32'hCAFE_F00D);

    // No reply: timeout on the 100th cycle in RX_HEADER
    exp_q.push_back(9'h000); exp_q.push_back(9'h000); exp_q.push_back(9'h000);
    exp_q.push_back(9'h000); exp_q.push_back(9'h008); exp_q.push_back(9'h000);
    exp_q.push_back(9'h000); exp_q.push_back(9'h140);
    axi_read_req(32'h0000_0008);
    cnt = 0;
    sample();
    while (dbg_state != ST_RX_HEADER && cnt < LIMIT) begin sample(); cnt++; end
    if (cnt >= LIMIT) check("reach_rx_header", 0, 1);
    cnt = 1;
    while (!timeout && cnt < LIMIT) begin sample(); cnt++; end
    check("timeout_cycle", cnt, 100);
    sample();
    check("timeout_one_pulse", {timeout, axil_rvalid}, 2'b01);
    wait_r("timeout_read", AXI_RESP_SLVERR, 32'd0);

    // Stale reply while idle is left untouched and answers nothing
    @(negedge clk);
    udp_rx_hdr_valid = 1'b1; udp_rx_ip_source_ip = 32'hC0A8_0101;
    udp_rx_source_port = 16'd1234; udp_rx_dest_port = 16'd1235;
    udp_rx_payload_tvalid = 1'b1; udp_rx_payload_tdata = 8'h78;
    any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      any = any | udp_rx_hdr_ready | udp_rx_payload_tready | axil_bvalid | axil_rvalid | busy;
    end
    check("stale_reply_ignored", any, 0);
    udp_rx_hdr_valid = 1'b0; udp_rx_payload_tvalid = 1'b0;

    // Reset during TX_PAYLOAD, then a clean write
    push_tx(64'h0000_0030_A5A5_A5A5);
    axi_write_req(32'h0000_0030, 32'hA5A5_A5A5, 4'hF);
    repeat (3) @(negedge clk);
    #1;
    check("in_tx_payload", dbg_state, ST_TX_PAYLOAD);
    reset_n = 1'b0;
    @(posedge clk);
    sample();
    check("reset_mid_tx_outputs", idle_vec(), 11'd0);
    check("reset_mid_tx_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
    push_tx(64'h0000_0020_0102_0304);
    axi_write_req(32'h0000_0020, 32'h0102_0304, 4'hF);
    send_rx(32'hC0A8_0101, 16'd1234, 16'd1235, 64'h8000_0020_0000_0000, 1'b0);
    wait_b("write_after_reset", AXI_RESP_OKAY);
    check("post_reset_tx_all_bytes", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
